// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          INST_BYTES = 4;

endpackage

// File: rtl/pc_legal_check.sv
// Combinational legality test for a fetch address: word aligned and the
// whole 4-byte word inside the instruction memory.
module pc_legal_check #(
  parameter int MEM_BYTES = 96
) (
  input  logic [64:0] addr,
  output logic        legal
);

  localparam logic [64:0] LIMIT = 65'(MEM_BYTES);

  logic aligned;
  logic in_range;

  // addr is 65 bits so a PC+4 that wrapped past 2^64 still compares as huge.
  assign aligned  = (addr[1:0] == 2'b00);
  assign in_range = ((addr + 65'd3) < LIMIT);
  assign legal    = aligned & in_range;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory and fills the IF/ID
// register, with stall, redirect and a sticky HALT on illegal fetch addresses.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 96,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [63:0]      Inst_Address,
  input  logic [31:0]      Instruction,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_target,
  output logic [63:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_valid,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_count,
  output fetch_state_t     state
);

  localparam bit BOOT_OK = (RESET_PC[1:0] == 2'b00) &&
                           (({1'b0, RESET_PC} + 65'd3) < 65'(MEM_BYTES));

  logic [63:0]      pc;
  logic [64:0]      seq_pc;
  logic             seq_legal;
  logic             target_legal;
  fetch_state_t     state_q;
  logic [63:0]      if_pc_q;
  logic [31:0]      if_inst_q;
  logic             if_valid_q;
  logic             fault_q;
  logic [CNT_W-1:0] count_q;

  assign seq_pc = {1'b0, pc} + 65'(INST_BYTES);

  pc_legal_check #(.MEM_BYTES(MEM_BYTES)) u_seq_check (
    .addr  (seq_pc),
    .legal (seq_legal)
  );

  pc_legal_check #(.MEM_BYTES(MEM_BYTES)) u_target_check (
    .addr  ({1'b0, redirect_target}),
    .legal (target_legal)
  );

  // Redirect beats stall; stall freezes PC and IF/ID together. A sequential
  // fetch whose successor is out of range still delivers, then parks the PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_inst_q  <= NOP;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
      state_q    <= BOOT;
    end else begin
      case (state_q)
        BOOT: begin
          if (BOOT_OK) begin
            state_q <= RUN;
          end else begin
            state_q <= HALT;
            fault_q <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            if_valid_q <= 1'b0;
            if (target_legal) begin
              pc <= redirect_target;
            end else begin
              state_q <= HALT;
              fault_q <= 1'b1;
            end
          end else if (!stall) begin
            if_pc_q    <= pc;
            if_inst_q  <= Instruction;
            if_valid_q <= 1'b1;
            count_q    <= count_q + CNT_W'(1);
            if (seq_legal) begin
              pc <= seq_pc[63:0];
            end else begin
              state_q <= HALT;
              fault_q <= 1'b1;
            end
          end
        end
        HALT: begin
          if_valid_q <= 1'b0;
          if (redirect_valid && target_legal) begin
            pc      <= redirect_target;
            fault_q <= 1'b0;
            state_q <= RUN;
          end
        end
        default: begin
          if_valid_q <= 1'b0;
          fault_q    <= 1'b1;
          state_q    <= HALT;
        end
      endcase
    end
  end

  assign Inst_Address = pc;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_valid     = if_valid_q;
  assign fetch_fault  = fault_q;
  assign fetch_count  = count_q;
  assign state        = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed plan scenarios then random
// stall/redirect/reset traffic, all checked against a cycle-level model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam int          MEM_BYTES = 96;
  localparam int          CNT_W     = 32;

  logic             clk;
  logic             reset;
  logic [63:0]      inst_address;
  logic [31:0]      instruction;
  logic             stall;
  logic             redirect_valid;
  logic [63:0]      redirect_target;
  logic [63:0]      if_pc;
  logic [31:0]      if_inst;
  logic             if_valid;
  logic             fetch_fault;
  logic [CNT_W-1:0] fetch_count;
  fetch_state_t     state;

  logic [31:0] mem [0:31];

  int passed;
  int total;

  // Reference model: what IF/ID should hold, derived from the fetch rules.
  logic [63:0] m_pc;
  logic [63:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_count;
  int          m_mode;   // 0 = just out of reset, 1 = fetching, 2 = halted

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Inst_Address    (inst_address),
    .Instruction     (instruction),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count),
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = (inst_address < 64'(MEM_BYTES)) ? mem[inst_address[6:2]] : 32'hDEAD_BEEF;

  function automatic bit addr_ok(input logic [63:0] a);
    return (a % 4 == 0) && (a <= 64'(MEM_BYTES - 4));
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pc = RESET_PC; m_if_pc = '0; m_if_inst = NOP; m_valid = 1'b0;
      m_fault = 1'b0; m_count = '0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (addr_ok(m_pc)) m_mode = 1;
      else begin m_mode = 2; m_fault = 1'b1; end
    end else if (m_mode == 1) begin
      if (redirect_valid) begin
        m_valid = 1'b0;
        if (addr_ok(redirect_target)) m_pc = redirect_target;
        else begin m_mode = 2; m_fault = 1'b1; end
      end else if (!stall) begin
        m_if_pc   = m_pc;
        m_if_inst = mem[m_pc / 4];
        m_valid   = 1'b1;
        m_count   = m_count + 1;
        if ({1'b0, m_pc} + 65'd4 <= 65'(MEM_BYTES - 4)) m_pc = m_pc + 4;
        else begin m_mode = 2; m_fault = 1'b1; end
      end
    end else begin
      m_valid = 1'b0;
      if (redirect_valid && addr_ok(redirect_target)) begin
        m_pc = redirect_target; m_fault = 1'b0; m_mode = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("inst_address", inst_address, m_pc);
    check("if_pc", if_pc, m_if_pc);
    check("if_inst", 64'(if_inst), 64'(m_if_inst));
    check("if_valid", 64'(if_valid), 64'(m_valid));
    check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    check("fetch_count", 64'(fetch_count), 64'(m_count));
  endtask

  // Inputs are set #1 after an edge; the model samples them at the next edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic st, input logic rv, input logic [63:0] rt);
    reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
  endtask

  initial begin
    logic [63:0] tgt;
    passed = 0;
    total  = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h1000_0513;
    mem[1] = 32'h0050_0293;
    mem[6] = 32'h045b_0463;

    // Reset values
    drive(1'b1, 1'b0, 1'b0, '0);
    tick(); tick();
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_inst", 64'(if_inst), 64'(NOP));
    check("rst_addr", inst_address, RESET_PC);
    check("rst_count", 64'(fetch_count), 64'd0);

    // Boot cycle then free run
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("boot_valid", 64'(if_valid), 64'd0);
    tick();
    check("first_pc", if_pc, 64'h0);
    check("first_inst", 64'(if_inst), 64'h1000_0513);
    check("first_valid", 64'(if_valid), 64'd1);
    tick();
    check("second_pc", if_pc, 64'h4);
    check("second_inst", 64'(if_inst), 64'h0050_0293);
    check("second_count", 64'(fetch_count), 64'd2);
    tick();

    // Stall three cycles with if_pc = 8
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", if_pc, 64'h8);
      check("stall_addr", inst_address, 64'hC);
      check("stall_count", 64'(fetch_count), 64'd3);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("resume_pc", if_pc, 64'hC);

    // Redirect together with stall
    drive(1'b0, 1'b1, 1'b1, 64'h18);
    tick();
    check("redir_valid", 64'(if_valid), 64'd0);
    check("redir_addr", inst_address, 64'h18);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("redir_pc", if_pc, 64'h18);
    check("redir_inst", 64'(if_inst), 64'h045b_0463);

    // Misaligned redirect halts; stall ignored; legal redirect recovers
    drive(1'b0, 1'b0, 1'b1, 64'h1A);
    tick();
    check("mis_fault", 64'(fetch_fault), 64'd1);
    check("mis_addr", inst_address, 64'h1C);
    drive(1'b0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("halt_valid", 64'(if_valid), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 64'h0);
    tick();
    check("clear_fault", 64'(fetch_fault), 64'd0);
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    check("refetch_pc", if_pc, 64'h0);
    check("refetch_valid", 64'(if_valid), 64'd1);

    // Run off the end of memory
    for (int i = 0; i < 23; i++) tick();
    check("last_pc", if_pc, 64'h5C);
    check("last_valid", 64'(if_valid), 64'd1);
    check("end_fault", 64'(fetch_fault), 64'd1);
    tick();
    check("end_valid", 64'(if_valid), 64'd0);
    check("end_addr", inst_address, 64'h5C);

    // Reset while halted with five deliveries
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 64'h4C);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) tick();
    check("halt5_count", 64'(fetch_count), 64'd5);
    check("halt5_fault", 64'(fetch_fault), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 64'h10);
    tick();
    check("hrst_fault", 64'(fetch_fault), 64'd0);
    check("hrst_count", 64'(fetch_count), 64'd0);
    check("hrst_valid", 64'(if_valid), 64'd0);
    check("hrst_addr", inst_address, RESET_PC);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: tgt = 64'($urandom_range(0, 23)) * 4;
        3:       tgt = 64'($urandom_range(0, 23)) * 4 + 64'($urandom_range(1, 3));
        4:       tgt = 64'(MEM_BYTES) + 64'($urandom_range(0, 10)) * 4;
        default: tgt = ($urandom_range(0, 1) == 1) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h5C;
      endcase
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, tgt);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
